detector_jogada: RTL and testbench
==================================

Name: detector_jogada

Overview:
- Input conditioner sitting directly upstream of the game control FSM.
- Synchronises and debounces the raw note-button vector.
- Produces the one-cycle `tem_jogada` strobe and the `tem_botao_pressionado` level that the FSM uses in espera_jogada / espera_soltar / mostrar_msg.
- Captures the pressed button (one-hot and encoded) for the button register and comparator. Multi-button presses are rejected.

Parameters:
- N_BOTOES, 7, number of note buttons.
- DEBOUNCE_CICLOS, 50000, cycles the synchronised vector must stay constant to be accepted (1 ms at 50 MHz); minimum 2.
- CNT_W, 16, debounce counter width; must hold DEBOUNCE_CICLOS-1.
- COD_W, 3, width of encoded button index; must hold N_BOTOES.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- botoes  in  N_BOTOES  raw asynchronous buttons, active-high.
- habilita  in  1  allows tem_jogada generation.
- tem_jogada  out  1  one-cycle strobe: valid single-button press accepted.
- tem_botao_pressionado  out  1  debounced "any button held" level.
- jogada  out  N_BOTOES  one-hot copy of last accepted press.
- codigo  out  COD_W  index+1 of last accepted button (bit0 -> 1); 0 = none.
- multiplo  out  1  high while a multi-button press is held.
- db_estado  out  2  current FSM state, for debug.

Behaviour:
- One clock domain. Only `reset` (synchronous, active-high) clears state. All outputs are 0 during and after reset until a new press.
- Synchroniser:
  - Two flops on `botoes` (sinc1, sinc2), reset to 0.
- Debounce (whole vector):
  - Registers: candidato, cnt, estavel; all reset to 0.
  - If sinc2 != candidato: candidato <= sinc2, cnt <= 0.
  - Else if cnt == DEBOUNCE_CICLOS-1: estavel <= candidato, and cnt holds.
  - Else cnt <= cnt+1.
- `tem_botao_pressionado` = (estavel != 0), combinational from estavel. It is independent of `habilita` and the FSM.
- FSM states (db_estado): LIVRE=0, PULSO=1, SEGURANDO=2, INVALIDO=3. Reset state is LIVRE.
  - LIVRE:
    - estavel == 0: stay.
    - estavel has exactly one bit set and habilita=1: go to PULSO. jogada <= estavel, codigo <= index+1.
    - exactly one bit and habilita=0: go to SEGURANDO; nothing captured.
    - two or more bits: go to INVALIDO.
  - PULSO: tem_jogada=1 for exactly this one cycle; then SEGURANDO unconditionally.
  - SEGURANDO: stay while estavel != 0; go to LIVRE when estavel == 0.
  - INVALIDO: multiplo=1; stay while estavel != 0; go to LIVRE when estavel == 0. No strobe and no capture.
- Latency: if botoes changes before edge 1 and is held, then:
  - estavel updates at edge DEBOUNCE_CICLOS+3.
  - tem_jogada is high between edges DEBOUNCE_CICLOS+4 and DEBOUNCE_CICLOS+5.
- Release: tem_botao_pressionado falls DEBOUNCE_CICLOS+3 edges after the release is sampled.
- Glitch shorter than DEBOUNCE_CICLOS cycles: estavel unchanged, no strobe.
- Held button: only one strobe per press. The button must be released and stable 0 before the next strobe.
- Press changing from one button directly to another without a stable 0 in between: no new strobe. estavel changes, the FSM stays in SEGURANDO, and jogada is unchanged.
- habilita falling while in PULSO: the strobe still completes that cycle.
- A button held across reset is re-debounced after reset. It yields a strobe once stable if habilita=1.
- jogada/codigo hold their value until the next accepted press or reset.

Test Plan:
- DEBOUNCE_CICLOS=4, habilita=1, reset, then botoes=0000100 held 20 cycles:
  - estavel at edge 7, tem_jogada high only after edge 8.
  - jogada=0000100, codigo=3, tem_botao_pressionado=1 from edge 7.
- Same setup, bounce botoes 0000001/0 toggling every cycle for 10 cycles, then 0:
  - no tem_jogada; tem_botao_pressionado stays 0; db_estado=0 throughout.
- Hold 0000001 for 50 cycles, release, hold 0100000:
  - exactly two strobes, codigo 1 then 6.
  - tem_botao_pressionado low for ≥1 cycle between them.
- botoes=0000011 held:
  - multiplo=1, db_estado=3, no strobe, jogada unchanged.
  - after release, multiplo=0 and db_estado=0.
- habilita=0 during a press of 0001000, then habilita=1 while still held:
  - no strobe until released and pressed again; next press gives codigo=4.
- Assert reset mid-press in PULSO:
  - next cycle all outputs 0, db_estado=0.
  - held button produces a new strobe at edge DEBOUNCE_CICLOS+4 after reset deasserts.

Source files
------------

// File: rtl/detector_jogada.sv
// rtl/detector_jogada.sv - note-button synchroniser, whole-vector debounce and single-press strobe FSM
module detector_jogada #(
    parameter int N_BOTOES        = 7,
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int CNT_W           = 16,
    parameter int COD_W           = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                habilita,
    output logic                tem_jogada,
    output logic                tem_botao_pressionado,
    output logic [N_BOTOES-1:0] jogada,
    output logic [COD_W-1:0]    codigo,
    output logic                multiplo,
    output logic [1:0]          db_estado
);

    typedef enum logic [1:0] {
        LIVRE     = 2'd0,
        PULSO     = 2'd1,
        SEGURANDO = 2'd2,
        INVALIDO  = 2'd3
    } estado_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

    logic [N_BOTOES-1:0] sinc1_q, sinc2_q;
    logic [N_BOTOES-1:0] candidato_q, candidato_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_BOTOES-1:0] estavel_q, estavel_d;
    estado_t             estado_q, estado_d;
    logic [N_BOTOES-1:0] jogada_q, jogada_d;
    logic [COD_W-1:0]    codigo_q, codigo_d;

    logic                um_bit;
    logic                algum_bit;
    logic [COD_W-1:0]    codigo_enc;

    always_ff @(posedge clock) begin
        if (reset) begin
            sinc1_q <= '0;
            sinc2_q <= '0;
        end else begin
            sinc1_q <= botoes;
            sinc2_q <= sinc1_q;
        end
    end

    // The whole vector must sit unchanged for DEBOUNCE_CICLOS cycles; any bit moving restarts the count.
    always_comb begin
        candidato_d = candidato_q;
        cnt_d       = cnt_q;
        estavel_d   = estavel_q;
        if (sinc2_q != candidato_q) begin
            candidato_d = sinc2_q;
            cnt_d       = '0;
        end else if (cnt_q == CNT_MAX) begin
            estavel_d = candidato_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            candidato_q <= '0;
            cnt_q       <= '0;
            estavel_q   <= '0;
        end else begin
            candidato_q <= candidato_d;
            cnt_q       <= cnt_d;
            estavel_q   <= estavel_d;
        end
    end

    assign algum_bit = (estavel_q != '0);
    assign um_bit    = algum_bit && ((estavel_q & (estavel_q - N_BOTOES'(1))) == '0);

    always_comb begin
        codigo_enc = '0;
        for (int i = 0; i < N_BOTOES; i++) begin
            if (estavel_q[i]) begin
                codigo_enc = COD_W'(i + 1);
            end
        end
    end

    // Capture happens only on the LIVRE->PULSO transition, so jogada/codigo hold across later presses.
    always_comb begin
        estado_d   = estado_q;
        jogada_d   = jogada_q;
        codigo_d   = codigo_q;
        tem_jogada = 1'b0;
        multiplo   = 1'b0;
        unique case (estado_q)
            LIVRE: begin
                if (algum_bit) begin
                    if (!um_bit) begin
                        estado_d = INVALIDO;
                    end else if (habilita) begin
                        estado_d = PULSO;
                        jogada_d = estavel_q;
                        codigo_d = codigo_enc;
                    end else begin
                        estado_d = SEGURANDO;
                    end
                end
            end
            PULSO: begin
                tem_jogada = 1'b1;
                estado_d   = SEGURANDO;
            end
            SEGURANDO: begin
                if (!algum_bit) begin
                    estado_d = LIVRE;
                end
            end
            INVALIDO: begin
                multiplo = 1'b1;
                if (!algum_bit) begin
                    estado_d = LIVRE;
                end
            end
            default: estado_d = LIVRE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= LIVRE;
            jogada_q <= '0;
            codigo_q <= '0;
        end else begin
            estado_q <= estado_d;
            jogada_q <= jogada_d;
            codigo_q <= codigo_d;
        end
    end

    assign tem_botao_pressionado = algum_bit;
    assign jogada                = jogada_q;
    assign codigo                = codigo_q;
    assign db_estado             = estado_q;

endmodule

// File: tb/tb_detector_jogada.sv
// tb/tb_detector_jogada.sv - directed vector bench for detector_jogada
module tb_detector_jogada;

    localparam int N = 7;
    localparam int D = 4;

    logic         clock;
    logic         reset;
    logic [N-1:0] botoes;
    logic         habilita;
    logic         tem_jogada;
    logic         tem_botao_pressionado;
    logic [N-1:0] jogada;
    logic [2:0]   codigo;
    logic         multiplo;
    logic [1:0]   db_estado;

    int n_vec = 0;
    int n_err = 0;

    detector_jogada #(
        .N_BOTOES       (N),
        .DEBOUNCE_CICLOS(D),
        .CNT_W          (16),
        .COD_W          (3)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .botoes               (botoes),
        .habilita             (habilita),
        .tem_jogada           (tem_jogada),
        .tem_botao_pressionado(tem_botao_pressionado),
        .jogada               (jogada),
        .codigo               (codigo),
        .multiplo             (multiplo),
        .db_estado            (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic         rst;
        logic [N-1:0] b;
        logic         hab;
        int           ciclos;
        int           strobes;
        logic         tbp;
        logic [N-1:0] jog;
        logic [2:0]   cod;
        logic         mult;
        logic [1:0]   est;
    } vetor_t;

    vetor_t tab[13];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_vec++;
        if (atual !== esperado) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        reset    = 1'b1;
        botoes   = '0;
        habilita = 1'b1;

        //          rst   botoes       hab  cyc str tbp  jogada       cod   mult  est
        tab[0]  = '{1'b1, 7'b0000000, 1'b1, 2,  0, 1'b0, 7'b0000000, 3'd0, 1'b0, 2'd0};
        tab[1]  = '{1'b0, 7'b0000001, 1'b1, 50, 1, 1'b1, 7'b0000001, 3'd1, 1'b0, 2'd2};
        tab[2]  = '{1'b0, 7'b0000000, 1'b1, 12, 0, 1'b0, 7'b0000001, 3'd1, 1'b0, 2'd0};
        tab[3]  = '{1'b0, 7'b0100000, 1'b1, 12, 1, 1'b1, 7'b0100000, 3'd6, 1'b0, 2'd2};
        tab[4]  = '{1'b0, 7'b0000010, 1'b1, 12, 0, 1'b1, 7'b0100000, 3'd6, 1'b0, 2'd2};
        tab[5]  = '{1'b0, 7'b0000000, 1'b1, 12, 0, 1'b0, 7'b0100000, 3'd6, 1'b0, 2'd0};
        tab[6]  = '{1'b0, 7'b0000011, 1'b1, 12, 0, 1'b1, 7'b0100000, 3'd6, 1'b1, 2'd3};
        tab[7]  = '{1'b0, 7'b0000000, 1'b1, 12, 0, 1'b0, 7'b0100000, 3'd6, 1'b0, 2'd0};
        tab[8]  = '{1'b0, 7'b0001000, 1'b0, 12, 0, 1'b1, 7'b0100000, 3'd6, 1'b0, 2'd2};
        tab[9]  = '{1'b0, 7'b0001000, 1'b1, 12, 0, 1'b1, 7'b0100000, 3'd6, 1'b0, 2'd2};
        tab[10] = '{1'b0, 7'b0000000, 1'b1, 12, 0, 1'b0, 7'b0100000, 3'd6, 1'b0, 2'd0};
        tab[11] = '{1'b0, 7'b0001000, 1'b1, 12, 1, 1'b1, 7'b0001000, 3'd4, 1'b0, 2'd2};
        tab[12] = '{1'b0, 7'b0000000, 1'b1, 12, 0, 1'b0, 7'b0001000, 3'd4, 1'b0, 2'd0};

        for (int v = 0; v < 13; v++) begin
            s        = 0;
            reset    = tab[v].rst;
            botoes   = tab[v].b;
            habilita = tab[v].hab;
            for (int c = 0; c < tab[v].ciclos; c++) begin
                step();
                if (tem_jogada === 1'b1) s++;
            end
            check($sformatf("v%0d strobes", v), s, tab[v].strobes);
            check($sformatf("v%0d tem_botao", v), tem_botao_pressionado, tab[v].tbp);
            check($sformatf("v%0d jogada", v), jogada, tab[v].jog);
            check($sformatf("v%0d codigo", v), codigo, tab[v].cod);
            check($sformatf("v%0d multiplo", v), multiplo, tab[v].mult);
            check($sformatf("v%0d db_estado", v), db_estado, tab[v].est);
            check($sformatf("v%0d tem_jogada", v), tem_jogada, 1'b0);
        end

        // Exact press latency and release latency
        botoes = 7'b0000100;
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("lat edge%0d tem_jogada", k), tem_jogada, (k == D + 4));
            check($sformatf("lat edge%0d tem_botao", k), tem_botao_pressionado, (k >= D + 3));
        end
        check("lat jogada", jogada, 7'b0000100);
        check("lat codigo", codigo, 3'd3);
        botoes = '0;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("rel edge%0d tem_botao", k), tem_botao_pressionado, (k < D + 3));
        end

        // Bounce faster than the debounce window
        for (int k = 0; k < 18; k++) begin
            botoes = (k < 10 && (k % 2) == 0) ? 7'b0000001 : 7'b0000000;
            step();
            check($sformatf("bounce %0d tem_jogada", k), tem_jogada, 1'b0);
            check($sformatf("bounce %0d tem_botao", k), tem_botao_pressionado, 1'b0);
            check($sformatf("bounce %0d db_estado", k), db_estado, 2'd0);
        end

        // habilita drop during PULSO, then reset while the button stays held
        botoes = 7'b0000010;
        for (int k = 1; k <= D + 4; k++) begin
            step();
            check($sformatf("pre edge%0d tem_jogada", k), tem_jogada, (k == D + 4));
        end
        habilita = 1'b0;
        #1;
        check("pulso hab0 tem_jogada", tem_jogada, 1'b1);
        reset = 1'b1;
        step();
        check("rst tem_jogada", tem_jogada, 1'b0);
        check("rst tem_botao", tem_botao_pressionado, 1'b0);
        check("rst jogada", jogada, 7'b0000000);
        check("rst codigo", codigo, 3'd0);
        check("rst multiplo", multiplo, 1'b0);
        check("rst db_estado", db_estado, 2'd0);
        reset    = 1'b0;
        habilita = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("post edge%0d tem_jogada", k), tem_jogada, (k == D + 4));
            check($sformatf("post edge%0d tem_botao", k), tem_botao_pressionado, (k >= D + 3));
        end
        check("post codigo", codigo, 3'd2);
        check("post jogada", jogada, 7'b0000010);
        botoes = '0;
        repeat (12) step();
        check("end db_estado", db_estado, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
